// File: rtl/mat_pkg.sv
// Shared definitions for the sequential N x N matrix multiplier.
// Holds the matrix dimension, element width, derived counter widths,
// FSM state encodings, the element type and index helpers.
package mat_pkg;

  localparam int unsigned N          = 5;
  localparam int unsigned W          = 32;
  localparam int unsigned NN         = N * N;
  localparam int unsigned LOAD_WORDS = 2 * NN;
  localparam int unsigned IDX_W      = $clog2(LOAD_WORDS);
  localparam int unsigned CELL_W     = $clog2(NN);
  localparam int unsigned DIM_W      = (N > 1) ? $clog2(N) : 1;

  typedef logic signed [W-1:0] elem_t;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  // Row-major flat index of element [row][col]
  function automatic logic [CELL_W-1:0] cell_idx(input logic [DIM_W-1:0] row,
                                                 input logic [DIM_W-1:0] col);
    return CELL_W'(row) * CELL_W'(N) + CELL_W'(col);
  endfunction

  // Identity-matrix element value at [row][col]
  function automatic elem_t ident_val(input logic [DIM_W-1:0] row,
                                      input logic [DIM_W-1:0] col);
    return (row == col) ? elem_t'(1) : elem_t'(0);
  endfunction

endpackage

// File: rtl/mat_mac.sv
// W-bit multiply-accumulate with synchronous clear.
// Ports:
//   clk, rst_n  clock / synchronous active-low reset
//   i_en        accumulate this cycle
//   i_clr       with i_en: drop the accumulator to 0 instead of storing the sum
//   i_a, i_b    operands (two's complement, only low W bits of product kept)
//   o_sum_c     combinational acc + a*b, wrapped to W bits
module mat_mac
  import mat_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum_c
);

  logic [W-1:0] r_acc;
  logic [W-1:0] w_prod;

  // Low W bits of a product are the same for signed and unsigned operands
  assign w_prod  = i_a * i_b;
  assign o_sum_c = r_acc + w_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_clr ? '0 : o_sum_c;
    end
  end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential N x N integer matrix multiplier, C = A * B mod 2^W, one MAC per clock.
// Operands stream in word-serial (A row-major, then B row-major); C streams out row-major.
// Optional feature macro: MAT_IDENT_CHECK_EN (is_ident flags C == identity during DRAIN).
// Ports:
//   clk, rst_n               clock / synchronous active-low reset
//   in_valid/in_ready/in_data    operand input handshake
//   out_valid/out_ready/out_data product output handshake, out_last marks C[N-1][N-1]
//   busy                     high in COMPUTE and DRAIN
//   is_ident                 identity flag (tied 0 when the feature is not built)
module mat_mult_seq
  import mat_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         is_ident
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  elem_t             r_a [NN];
  elem_t             r_b [NN];
  elem_t             r_c [NN];
  logic [IDX_W-1:0]  r_load_cnt;
  logic [DIM_W-1:0]  r_i, r_j, r_k;
  logic [CELL_W-1:0] r_out_cnt;

  logic              w_load_hs, w_last_load, w_load_b;
  logic [CELL_W-1:0] w_load_cell, w_c_cell, w_out_nxt;
  logic              w_mac_en, w_k_last, w_j_last, w_i_last, w_last_mac;
  logic              w_out_hs, w_last_out;
  logic [W-1:0]      w_sum;

  assign w_load_hs   = (r_state == ST_LOAD) && in_valid && in_ready;
  assign w_last_load = w_load_hs && (r_load_cnt == IDX_W'(LOAD_WORDS - 1));
  assign w_load_b    = (r_load_cnt >= IDX_W'(NN));
  assign w_load_cell = w_load_b ? CELL_W'(r_load_cnt - IDX_W'(NN)) : CELL_W'(r_load_cnt);

  assign w_mac_en   = (r_state == ST_COMPUTE);
  assign w_k_last   = (r_k == DIM_W'(N - 1));
  assign w_j_last   = (r_j == DIM_W'(N - 1));
  assign w_i_last   = (r_i == DIM_W'(N - 1));
  assign w_last_mac = w_mac_en && w_k_last && w_j_last && w_i_last;
  assign w_c_cell   = cell_idx(r_i, r_j);

  assign w_out_hs   = (r_state == ST_DRAIN) && out_valid && out_ready;
  assign w_last_out = w_out_hs && out_last;
  assign w_out_nxt  = r_out_cnt + CELL_W'(1);

  mat_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_mac_en),
    .i_clr   (w_k_last),
    .i_a     (r_a[cell_idx(r_i, r_k)]),
    .i_b     (r_b[cell_idx(r_k, r_j)]),
    .o_sum_c (w_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:    if (w_last_load) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (w_last_mac)  w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_last_out)  w_state_nxt = ST_LOAD;
      default:    w_state_nxt = ST_LOAD;
    endcase
  end

  // Operand and product storage; contents are simply overwritten by the next pass
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_load_hs) begin
        if (w_load_b) r_b[w_load_cell] <= in_data;
        else          r_a[w_load_cell] <= in_data;
      end
      if (w_mac_en && w_k_last) r_c[w_c_cell] <= w_sum;
    end
  end

  // Counters and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      out_data   <= '0;
      r_load_cnt <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_out_cnt  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_last_load) begin
            r_load_cnt <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
          end else if (w_load_hs) begin
            r_load_cnt <= r_load_cnt + IDX_W'(1);
          end
        end
        ST_COMPUTE: begin
          // k innermost, then j, then i
          if (!w_k_last) begin
            r_k <= r_k + DIM_W'(1);
          end else begin
            r_k <= '0;
            if (!w_j_last) begin
              r_j <= r_j + DIM_W'(1);
            end else begin
              r_j <= '0;
              if (!w_i_last) begin
                r_i <= r_i + DIM_W'(1);
              end else begin
                r_i       <= '0;
                r_out_cnt <= '0;
                out_valid <= 1'b1;
                // A 1x1 product is being written on this very edge
                out_data  <= (NN == 1) ? w_sum : r_c[0];
                out_last  <= (NN == 1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_last_out) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_out_cnt <= '0;
          end else if (w_out_hs) begin
            r_out_cnt <= w_out_nxt;
            out_data  <= r_c[w_out_nxt];
            out_last  <= (w_out_nxt == CELL_W'(NN - 1));
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAT_IDENT_CHECK_EN
  logic r_ident_ok;
  logic w_c_match;

  assign w_c_match = (w_sum == ident_val(r_i, r_j));

  // Running identity check over every C write of the current pass
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ident_ok <= 1'b0;
      is_ident   <= 1'b0;
    end else begin
      if (w_last_load)                r_ident_ok <= 1'b1;
      else if (w_mac_en && w_k_last)  r_ident_ok <= r_ident_ok & w_c_match;
      if (w_last_mac)                 is_ident   <= r_ident_ok & w_c_match;
      else if (w_last_out)            is_ident   <= 1'b0;
    end
  end
`else
  assign is_ident = 1'b0;
`endif

endmodule
